// File: rtl/filter_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter family.
package filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

  localparam int CTRL_CLR_BIT = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/filter_sat.sv
// Arithmetic/logical right shift of a MAC accumulator followed by
// clamping into the YW-bit output range.
module filter_sat #(
  parameter int ACC_W  = 18,
  parameter int YW     = 16,
  parameter int SHIFT  = 0,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] acc,
  output logic [YW-1:0]    y
);

  // One spare bit above the wider operand keeps every comparison signed-safe.
  localparam int WW = ((ACC_W > YW) ? ACC_W : YW) + 1;

  localparam logic signed [WW-1:0] S_MAX = {{(WW-YW+1){1'b0}}, {(YW-1){1'b1}}};
  localparam logic signed [WW-1:0] S_MIN = {{(WW-YW+1){1'b1}}, {(YW-1){1'b0}}};
  localparam logic signed [WW-1:0] U_MAX = {{(WW-YW){1'b0}}, {YW{1'b1}}};
  localparam logic signed [WW-1:0] HI    = (SIGNED != 0) ? S_MAX : U_MAX;
  localparam logic signed [WW-1:0] LO    = (SIGNED != 0) ? S_MIN : '0;

  logic signed [WW-1:0] wide;

  always_comb begin
    if (SIGNED != 0) wide = WW'($signed(acc) >>> SHIFT);
    else             wide = WW'(acc >> SHIFT);
    y = wide[YW-1:0];
    if (wide > HI)      y = HI[YW-1:0];
    else if (wide < LO) y = LO[YW-1:0];
  end

endmodule

// File: rtl/filter_mac.sv
// Parametrised FIR filter: one multiplier iterated over TAPS coefficients per
// accepted sample, with CPU-written coefficients, input mask and history clear.
module filter_mac
  import filter_pkg::*;
#(
  parameter int TAPS   = 8,
  parameter int XW     = 8,
  parameter int CW     = 8,
  parameter int YW     = 16,
  parameter int SHIFT  = 0,
  parameter int SIGNED = 0,
  parameter int AW     = 16
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          w_en_n,
  input  logic [AW-1:0] addr,
  input  logic [CW-1:0] p,
  output logic          cfg_drop,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [XW-1:0] x,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [YW-1:0] y,
  output logic          busy
);

  localparam int KW    = clog2(TAPS);
  localparam int ACC_W = XW + CW + clog2(TAPS);

  localparam logic [AW-1:0] MASK_ADDR = AW'(TAPS);
  localparam logic [AW-1:0] CTRL_ADDR = AW'(TAPS + 1);
  localparam logic [KW-1:0] LAST_K    = KW'(TAPS - 1);

  state_t state, state_next;

  logic [CW-1:0]    coef [TAPS];
  logic [XW-1:0]    hist [TAPS];
  logic [XW-1:0]    mask;
  logic [XW-1:0]    mask_eff;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] acc_sum;
  logic [KW-1:0]    k;
  logic [YW-1:0]    y_sat;

  logic wr_idle;
  logic wr_coef;
  logic wr_mask;
  logic wr_clr;
  logic accept;

  assign wr_idle  = !w_en_n && (state == ST_IDLE);
  assign wr_coef  = wr_idle && (addr < MASK_ADDR);
  assign wr_mask  = wr_idle && (addr == MASK_ADDR);
  assign wr_clr   = wr_idle && (addr == CTRL_ADDR) && p[CTRL_CLR_BIT];
  assign accept   = x_ready && x_valid;
  // A mask written in the accept cycle already applies to that sample.
  assign mask_eff = wr_mask ? p[XW-1:0] : mask;

  always_comb begin
    if (SIGNED != 0) prod = ACC_W'($signed(coef[k])) * ACC_W'($signed(hist[k]));
    else             prod = ACC_W'(coef[k]) * ACC_W'(hist[k]);
    acc_sum = acc + prod;
  end

  filter_sat #(
    .ACC_W (ACC_W),
    .YW    (YW),
    .SHIFT (SHIFT),
    .SIGNED(SIGNED)
  ) u_sat (
    .acc(acc_sum),
    .y  (y_sat)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    x_ready    = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        x_ready = 1'b1;
        if (x_valid) state_next = ST_MAC;
      end
      ST_MAC: begin
        busy = 1'b1;
        if (k == LAST_K) state_next = ST_OUT;
      end
      ST_OUT: begin
        busy = 1'b1;
        if (y_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
        hist[i] <= '0;
      end
      mask     <= '1;
      acc      <= '0;
      k        <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      cfg_drop <= 1'b0;
    end else begin
      cfg_drop <= !w_en_n && (state != ST_IDLE);
      if (wr_coef) coef[addr[KW-1:0]] <= p;
      if (wr_mask) mask <= p[XW-1:0];

      // A clear in the accept cycle leaves only the new sample in the history.
      if (accept) begin
        hist[0] <= x & mask_eff;
        for (int i = 1; i < TAPS; i++) hist[i] <= wr_clr ? '0 : hist[i-1];
        acc <= '0;
        k   <= '0;
      end else if (wr_clr) begin
        for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      end

      if (state == ST_MAC) begin
        acc <= acc_sum;
        k   <= k + 1'b1;
        if (k == LAST_K) begin
          y       <= y_sat;
          y_valid <= 1'b1;
        end
      end

      if ((state == ST_OUT) && y_ready) y_valid <= 1'b0;
    end
  end

endmodule
